// File: rtl/snake_key_input.sv
// rtl/snake_key_input.sv - Debounced key inputs feeding a step-synchronised snake heading
// Optional feature macro: KEY_AUTOREPEAT_EN (held keys re-pulse key_pressed)
module snake_key_input #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                clock,
    input  logic                resetHW,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic                step_tick,
    output logic [NUM_KEYS-1:0] keys_stable,
    output logic [NUM_KEYS-1:0] key_pressed,
    output logic [1:0]          direction,
    output logic                dir_changed,
    output logic                pending_valid
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]                  rst_sync_q, rst_sync_d;
    logic                        rst_n;
    logic [NUM_KEYS-1:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NUM_KEYS-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NUM_KEYS-1:0]         stable_q, stable_d, stable_prev_q, stable_prev_d;
    logic [NUM_KEYS-1:0]         pressed_q, pressed_d, rise;
    logic [1:0]                  dir_q, dir_d, pend_dir_q, pend_dir_d;
    logic [1:0]                  ref_dir, req_dir;
    logic                        pend_valid_q, pend_valid_d, changed_q, changed_d, req_valid;

    // Reset asserts immediately but is released two clock edges after resetHW rises
    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge clock or negedge resetHW) begin
        if (!resetHW) rst_sync_q <= 2'b00;
        else          rst_sync_q <= rst_sync_d;
    end

    assign rst_n = rst_sync_q[1];

    always_comb begin
        sync1_d       = keys;
        sync2_d       = sync1_q;
        stable_d      = stable_q;
        stable_prev_d = stable_q;
        cnt_d         = cnt_q;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt_d[i]    = '0;
                stable_d[i] = sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    assign rise = stable_q & ~stable_prev_q;

`ifdef KEY_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(RPT_MAX + 1);

    logic [NUM_KEYS-1:0][RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [NUM_KEYS-1:0]         rpt_phase_q, rpt_phase_d, rpt_fire;

    // Counter restarts at every pulse; phase 0 times the first delay, phase 1 the period
    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_phase_d = rpt_phase_q;
        rpt_fire    = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (!(stable_q[i] && stable_prev_q[i])) begin
                rpt_cnt_d[i]   = '0;
                rpt_phase_d[i] = 1'b0;
            end else if (rpt_cnt_q[i] == (rpt_phase_q[i] ? RW'(REPEAT_PERIOD - 1)
                                                         : RW'(REPEAT_DELAY - 1))) begin
                rpt_fire[i]    = 1'b1;
                rpt_cnt_d[i]   = '0;
                rpt_phase_d[i] = 1'b1;
            end else begin
                rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
            end
        end
        pressed_d = rise | rpt_fire;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q   <= '0;
            rpt_phase_q <= '0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_phase_q <= rpt_phase_d;
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};

    always_comb pressed_d = rise;
`endif

    always_comb begin
        dir_d        = dir_q;
        pend_dir_d   = pend_dir_q;
        pend_valid_d = pend_valid_q;
        changed_d    = 1'b0;
        req_valid    = |pressed_q[3:0];
        if (pressed_q[0])      req_dir = 2'd0;
        else if (pressed_q[1]) req_dir = 2'd1;
        else if (pressed_q[2]) req_dir = 2'd2;
        else                   req_dir = 2'd3;
        if (step_tick && pend_valid_q) begin
            dir_d        = pend_dir_q;
            pend_valid_d = 1'b0;
            changed_d    = 1'b1;
        end
        // A same-cycle commit makes the pending heading the new direction, so either way it is the reference
        ref_dir = pend_valid_q ? pend_dir_q : dir_q;
        if (req_valid && (req_dir != ref_dir) && (req_dir != (ref_dir ^ 2'b10))) begin
            pend_dir_d   = req_dir;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            cnt_q         <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            pressed_q     <= '0;
            dir_q         <= 2'b00;
            pend_dir_q    <= 2'b00;
            pend_valid_q  <= 1'b0;
            changed_q     <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            pressed_q     <= pressed_d;
            dir_q         <= dir_d;
            pend_dir_q    <= pend_dir_d;
            pend_valid_q  <= pend_valid_d;
            changed_q     <= changed_d;
        end
    end

    assign keys_stable   = stable_q;
    assign key_pressed   = pressed_q;
    assign direction     = dir_q;
    assign dir_changed   = changed_q;
    assign pending_valid = pend_valid_q;
endmodule

// File: tb/tb_snake_key_input.sv
// tb/tb_snake_key_input.sv - Directed and randomised self-checking bench for snake_key_input
module tb_snake_key_input;
    localparam int N  = 5;
    localparam int D  = 8;
    localparam int RD = 20;
    localparam int RP = 10;

    logic         clock     = 1'b0;
    logic         resetHW   = 1'b1;
    logic [N-1:0] keys      = '0;
    logic         step_tick = 1'b0;
    logic [N-1:0] keys_stable, key_pressed;
    logic [1:0]   direction;
    logic         dir_changed, pending_valid;

    snake_key_input #(
        .NUM_KEYS(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clock(clock), .resetHW(resetHW), .keys(keys), .step_tick(step_tick),
        .keys_stable(keys_stable), .key_pressed(key_pressed), .direction(direction),
        .dir_changed(dir_changed), .pending_valid(pending_valid)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: raw samples arrive two edges late, a level is accepted after a run of D equal samples
    logic [N-1:0] raw_q[$];
    int           run_len[N];
    logic [N-1:0] run_val, m_stable, m_stable_d1, m_pressed;
    logic [1:0]   m_dir, m_pend;
    logic         m_pv, m_chg;
    int           rel_edges, edge_no;
`ifdef KEY_AUTOREPEAT_EN
    int           last_fire[N], nrep[N];
`endif

    task automatic model_reset();
        raw_q.delete();
        raw_q.push_back('0);
        raw_q.push_back('0);
        for (int i = 0; i < N; i++) run_len[i] = 0;
        run_val = '0; m_stable = '0; m_stable_d1 = '0; m_pressed = '0;
        m_dir = 2'b00; m_pend = 2'b00; m_pv = 1'b0; m_chg = 1'b0;
        rel_edges = 0;
    endtask

    task automatic model_edge();
        logic [N-1:0] old_pressed, new_pressed, smp;
        logic [1:0]   req, ref_dir;
        edge_no++;
        if (!resetHW) begin
            model_reset();
            return;
        end
        if (rel_edges < 2) begin
            rel_edges++;
            return;
        end
        old_pressed = m_pressed;
        new_pressed = m_stable & ~m_stable_d1;
`ifdef KEY_AUTOREPEAT_EN
        for (int i = 0; i < N; i++) begin
            if (new_pressed[i]) begin
                last_fire[i] = edge_no;
                nrep[i]      = 0;
            end else if (m_stable[i] && m_stable_d1[i] &&
                         (edge_no - last_fire[i] == ((nrep[i] == 0) ? RD : RP))) begin
                new_pressed[i] = 1'b1;
                last_fire[i]   = edge_no;
                nrep[i]++;
            end
        end
`endif
        m_stable_d1 = m_stable;
        raw_q.push_back(keys);
        smp = raw_q.pop_front();
        for (int i = 0; i < N; i++) begin
            if (smp[i] == run_val[i]) run_len[i]++;
            else begin
                run_val[i] = smp[i];
                run_len[i] = 1;
            end
            if (smp[i] != m_stable[i] && run_len[i] >= D) m_stable[i] = smp[i];
        end
        m_chg = 1'b0;
        if (step_tick && m_pv) begin
            m_dir = m_pend;
            m_pv  = 1'b0;
            m_chg = 1'b1;
        end
        if (|old_pressed[3:0]) begin
            req = 2'd0;
            for (int i = 3; i >= 0; i--) if (old_pressed[i]) req = 2'(i);
            ref_dir = m_pv ? m_pend : m_dir;
            if (req != ref_dir && req != (ref_dir ^ 2'b10)) begin
                m_pend = req;
                m_pv   = 1'b1;
            end
        end
        m_pressed = new_pressed;
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check("keys_stable", 32'(keys_stable), 32'(m_stable));
        check("key_pressed", 32'(key_pressed), 32'(m_pressed));
        check("direction", 32'(direction), 32'(m_dir));
        check("dir_changed", 32'(dir_changed), 32'(m_chg));
        check("pending_valid", 32'(pending_valid), 32'(m_pv));
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input int k);
        keys[k] = 1'b1;
        ticks(D + 6);
        keys[k] = 1'b0;
        ticks(D + 6);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({keys_stable, key_pressed, direction, dir_changed, pending_valid});
    endfunction

    initial begin
        int first_s, first_p, npulse;
        logic [N-1:0] acc;
        int pt[$];
        edge_no = 0;
        model_reset();
        #2 resetHW = 1'b0;
        #1 check("reset_state", all_outs(), 32'd0);
        ticks(3);
        resetHW = 1'b1;
        ticks(6);

        keys = 5'b00001;
        first_s = 0; first_p = 0; npulse = 0;
        for (int t = 1; t <= D + 6; t++) begin
            tick();
            if (keys_stable[0] && first_s == 0) first_s = t;
            if (key_pressed[0]) begin
                npulse++;
                if (first_p == 0) first_p = t;
            end
        end
        check("debounce_latency", 32'(first_s), 32'(D + 2));
        check("press_cycle", 32'(first_p), 32'(D + 3));
        check("press_count", 32'(npulse), 32'd1);
        keys = '0;
        ticks(D + 6);

        acc = '0;
        for (int t = 0; t < 100; t++) begin
            if (t % 5 == 0) keys[1] = ~keys[1];
            tick();
            acc |= keys_stable | key_pressed;
        end
        check("bounce_rejected", 32'(acc), 32'd0);
        keys = '0;
        ticks(D + 6);

        press(2);
        check("reversal_pending", 32'(pending_valid), 32'd0);
        step_tick = 1'b1; tick(); step_tick = 1'b0;
        check("reversal_dir", 32'(direction), 32'd0);
        check("reversal_changed", 32'(dir_changed), 32'd0);

        press(1);
        check("up_pending", 32'(pending_valid), 32'd1);
        press(2);
        check("left_pending", 32'(pending_valid), 32'd1);
        check("dir_held", 32'(direction), 32'd0);
        step_tick = 1'b1; tick(); step_tick = 1'b0;
        check("commit_left", 32'(direction), 32'd2);
        check("commit_pulse", 32'(dir_changed), 32'd1);
        npulse = 0;
        repeat (5) begin
            tick();
            npulse += int'(dir_changed);
        end
        check("commit_once", 32'(npulse), 32'd0);

        press(1);
        check("up_pending2", 32'(pending_valid), 32'd1);
        keys[3] = 1'b1;
        ticks(D + 3);
        check("down_pulse", 32'(key_pressed[3]), 32'd1);
        step_tick = 1'b1; tick(); step_tick = 1'b0;
        check("same_cycle_dir", 32'(direction), 32'd1);
        check("same_cycle_changed", 32'(dir_changed), 32'd1);
        check("down_rejected", 32'(pending_valid), 32'd0);
        keys[3] = 1'b0;
        ticks(D + 6);

        press(0);
        check("right_pending", 32'(pending_valid), 32'd1);
        keys[2] = 1'b1;
        ticks(4);
        #2 resetHW = 1'b0;
        #1 check("async_clear", all_outs(), 32'd0);
        model_reset();
        ticks(3);
        resetHW = 1'b1;
        first_p = 0;
        for (int t = 1; t <= D + 10; t++) begin
            tick();
            if (key_pressed[2] && first_p == 0) first_p = t;
        end
        check("held_through_reset", 32'(first_p >= D + 3 && first_p <= D + 8), 32'd1);
        keys = '0;
        ticks(D + 6);

        keys[4] = 1'b1;
        for (int t = 1; t <= 70; t++) begin
            tick();
            if (key_pressed[4]) pt.push_back(t);
        end
        check("key4_no_steer", 32'({direction, pending_valid}), 32'd0);
`ifdef KEY_AUTOREPEAT_EN
        check("repeat_count", 32'(pt.size()), 32'd5);
        if (pt.size() >= 3) begin
            check("repeat_delay", 32'(pt[1] - pt[0]), 32'(RD));
            check("repeat_period", 32'(pt[2] - pt[1]), 32'(RP));
        end
`else
        check("single_pulse_held", 32'(pt.size()), 32'd1);
`endif
        keys = '0;
        ticks(D + 6);

        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) if ($urandom_range(0, 19) == 0) keys[k] = ~keys[k];
            step_tick = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 999) == 0) begin
                #2 resetHW = 1'b0;
                #1 check("rand_async_clear", all_outs(), 32'd0);
                model_reset();
                ticks(2);
                resetHW = 1'b1;
            end
            tick();
        end
        step_tick = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/snake_key_input.md
SNAKE_KEY_INPUT -- requirements
Module: snake_key_input

Interface
REQ-001 The block SHALL have parameter NUM_KEYS, default 4, meaning the number of raw key channels; legal values are 4 to 16.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive agreeing samples required to accept a level change; legal values are 2 to 2^24-1.
REQ-003 The block SHALL have parameters REPEAT_DELAY, default 25000000, and REPEAT_PERIOD, default 5000000, both in clock cycles and both used only under KEY_AUTOREPEAT_EN.
REQ-004 The block SHALL have port clock, input, width 1: single rising-edge clock.
REQ-005 The block SHALL have port resetHW, input, width 1: reset, asynchronous and active-low.
REQ-006 The block SHALL have port keys, input, width NUM_KEYS: raw asynchronous key levels, 1 = pressed; bits [3:0] are right, up, left, down.
REQ-007 The block SHALL have port step_tick, input, width 1: single-cycle game-step strobe.
REQ-008 The block SHALL have port keys_stable, output, width NUM_KEYS: debounced key levels.
REQ-009 The block SHALL have port key_pressed, output, width NUM_KEYS: single-cycle press pulses.
REQ-010 The block SHALL have port direction, output, width 2: committed heading, 00 right, 01 up, 10 left, 11 down.
REQ-011 The block SHALL have port dir_changed, output, width 1: single-cycle pulse when direction updates.
REQ-012 The block SHALL have port pending_valid, output, width 1: a direction request awaits step_tick.

Function
REQ-013 Each key bit SHALL pass through a 2-flop synchroniser before any other logic.
REQ-014 Each channel SHALL have an independent counter, cleared whenever the synchronised sample equals keys_stable or the counter reaches DEBOUNCE_CYCLES-1, and incremented otherwise.
REQ-015 keys_stable[i] SHALL take the synchronised value on the cycle its counter reaches DEBOUNCE_CYCLES-1; any disagreeing sample before that restarts the count.
REQ-016 Latency from a clean raw edge to the keys_stable change SHALL be exactly DEBOUNCE_CYCLES+2 cycles.
REQ-017 key_pressed[i] SHALL pulse high for exactly one cycle, in the cycle after keys_stable[i] rises; a release SHALL produce no pulse.
REQ-018 A direction request SHALL be generated only by key_pressed[3:0]; if several bits pulse in the same cycle, the lowest index SHALL win.
REQ-019 A request SHALL be rejected if it equals the reference direction or equals the reference direction XOR 2'b10 (reversal).
REQ-020 The reference direction SHALL be the pending direction when pending_valid=1, and direction otherwise.
REQ-021 An accepted request SHALL overwrite the pending direction and set pending_valid.
REQ-022 On step_tick with pending_valid=1, the block SHALL load direction from the pending direction, clear pending_valid, and pulse dir_changed for one cycle.
REQ-023 On step_tick with pending_valid=0, the block SHALL take no action.
REQ-024 When step_tick and a request occur in the same cycle, the block SHALL commit the old pending direction first, then evaluate the request against the newly committed direction and, if accepted, hold it pending.
REQ-025 Keys with index 4 and above SHALL affect only keys_stable and key_pressed.

Reset
REQ-026 When resetHW is low, all flops SHALL clear asynchronously: synchronisers, counters, keys_stable and key_pressed to 0, direction to 00, pending_valid and dir_changed to 0.
REQ-027 Reset release SHALL be synchronised to clock; a key held through reset SHALL produce a press pulse only after DEBOUNCE_CYCLES+2 cycles.

Configuration
REQ-028 With macro KEY_AUTOREPEAT_EN defined, a key whose keys_stable stays high SHALL re-pulse key_pressed REPEAT_DELAY cycles after the first pulse, then every REPEAT_PERIOD cycles until it is released.
REQ-029 Without KEY_AUTOREPEAT_EN, the repeat counters SHALL be absent and exactly one pulse SHALL occur per press.

Verification
REQ-030 Test: with DEBOUNCE_CYCLES=8, hold keys=4'b0001 from cycle 0 -> keys_stable[0] is 1 at cycle 10 and key_pressed[0] pulses once at cycle 11.
REQ-031 Test: toggle keys[1] every 5 cycles for 100 cycles with DEBOUNCE_CYCLES=8 -> keys_stable and key_pressed stay 0 throughout.
REQ-032 Test: with direction 00, press left (keys=4'b0100), then pulse step_tick -> request rejected, pending_valid=0, direction stays 00, and no dir_changed pulse.
REQ-033 Test: with direction 00, press up then left before step_tick -> pending is 10 after both presses; the next step_tick sets direction to 10 with one dir_changed pulse.
REQ-034 Test: pulse step_tick with pending 01 while down is pressed in the same cycle -> direction becomes 01 and the down request is rejected.
REQ-035 Test: assert resetHW low mid-debounce and mid-pending -> all outputs are 0 within the same cycle; with KEY_AUTOREPEAT_EN and REPEAT_DELAY=20, REPEAT_PERIOD=10, a held key pulses at t, t+20, t+30.
